pcileech_tlps64_tx_arbiter: RTL and testbench
=============================================

Name: pcileech_tlps64_tx_arbiter

Overview:
Shares the single PCIe core AXI TX stream between up to NUM_SRC TLP sources, e.g. the TLP FIFO path, the config-space responder and the BAR read engine.
- Round-robin arbitration with the grant locked for a whole packet, from first beat until the beat with last.
- Each source is gated by its bit in the per-source enable mask (tlp_tx_en from the PCIe CFG module) and by core TX buffer availability (tx_buf_av).
- Sits between the TLP sources and the core s_axis_tx port.

Parameters:
NUM_SRC, 4, number of source streams (2..4); width of tlp_tx_en.
MIN_BUF_AV, 2, minimum tx_buf_av needed to start a new packet.
MAX_BEATS, 18, maximum legal beats per packet (4 DW header + 32 DW data, 2 DW per beat).

Ports:
clk  in  1  clock, all logic on its rising edge.
rst_n  in  1  asynchronous active-low reset.
tlp_tx_en  in  NUM_SRC  per-source enable; bit i gates source i.
tx_buf_av  in  6  core TX buffers available.
src_data  in  NUM_SRC*64  source data; source i occupies [64*i+63:64*i].
src_keep  in  NUM_SRC*8  source byte keep; source i occupies [8*i+7:8*i].
src_last  in  NUM_SRC  source last beat.
src_valid  in  NUM_SRC  source beat valid.
src_ready  out  NUM_SRC  ready back to each source.
tx_data  out  64  data to core.
tx_keep  out  8  keep to core.
tx_last  out  1  last to core.
tx_valid  out  1  valid to core.
tx_ready  in  1  ready from core.
grant  out  NUM_SRC  one-hot current owner; 0 when idle.
err_overlen  out  1  sticky: a packet exceeded MAX_BEATS.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, err_overlen=0.
  - tx_valid=0, src_ready=0, tx_data/tx_keep/tx_last=0.
  - Reset mid-packet abandons the packet; no beat is emitted after reset deasserts until a new arbitration completes.
- Eligibility: req[i] = src_valid[i] & tlp_tx_en[i].
- Start condition: a new packet may start only if tx_buf_av >= MIN_BUF_AV (unsigned compare).
- IDLE state:
  - tx_valid=0, src_ready=0.
  - If the start condition holds and any req[i] is set: select the first set req scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - Register the selection into grant (one-hot), clear beat_cnt, go to XFER.
  - Arbitration costs exactly 1 cycle; the first beat can transfer on the cycle after the request is seen.
- XFER state, combinational pass-through of the granted source g:
  - tx_data/keep/last/valid = src_*[g]; src_ready[g] = tx_ready; src_ready[others] = 0.
  - A beat transfers when tx_valid & tx_ready; beat_cnt increments on each transfer.
  - Zero added latency per beat; source stalls and core back-pressure propagate the same cycle.
- End of packet: a transfer with tx_last=1 moves to IDLE, sets grant=0 and rr_ptr=(g+1) mod NUM_SRC.
  - Minimum 1 idle cycle between packets.
  - Sustained throughput for 18-beat packets is 18/19.
- tlp_tx_en bit cleared mid-packet: the current packet completes normally. The mask affects arbitration only.
- tx_buf_av dropping mid-packet: ignored; the core's own tx_ready governs.
- Over-length packet: on a transfer when beat_cnt == MAX_BEATS (the beat would be number MAX_BEATS+1):
  - Set err_overlen (stays set until reset).
  - Keep passing beats through; there is no truncation.
  - beat_cnt saturates at MAX_BEATS+1.
- Source deasserting src_valid mid-packet: tx_valid follows it to 0; the grant is held with no timeout.
- Simultaneous requests: strict round-robin from rr_ptr, so no source is granted twice while another eligible source waits.
- Single-beat packet (last on the first beat): returns to IDLE after one transfer.

Test Plan:
- Reset then idle: rst_n=0 with all src_valid=1 -> tx_valid=0, src_ready=0, grant=0; after release with tlp_tx_en=4'hF, tx_buf_av=8 -> grant=4'b0001 one cycle later.
- Fairness: all 4 sources continuously offer 3-beat packets -> grant sequence 0001,0010,0100,1000,0001; each packet is 3 beats then 1 idle cycle; no interleaving of beats.
- Mask and buffer gating:
  - tlp_tx_en=4'b0100 with all valid -> only source 2 is granted.
  - tx_buf_av=1 -> no grant while IDLE.
  - Raising tx_buf_av to 2 -> grant on the next cycle.
- Back-pressure mid-packet: toggle tx_ready 1,0,0,1 during an 18-beat packet from source 1 -> src_ready[1] mirrors tx_ready, all 18 beats arrive in order, grant is held, err_overlen=0.
- Over-length: source 0 sends a 19-beat packet -> err_overlen rises on beat 19 and stays 1 through later legal packets until rst_n=0.
- Reset mid-packet: assert rst_n=0 at beat 5 of 10 -> tx_valid=0 immediately; after release the next packet starts at rr_ptr=0 with beat_cnt=0.

Source files
------------

// File: rtl/pcileech_tlps64_tx_arbiter.sv
// Round-robin arbiter that shares the PCIe core AXI TX stream between several TLP sources.
// A grant is held for a whole packet; once granted, beats pass straight through.
//
// state | meaning
// IDLE  | no owner; arbitrate when tx_buf_av allows and a source is eligible
// XFER  | granted source passes through to the core until its last beat
module pcileech_tlps64_tx_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int MIN_BUF_AV = 2,
   parameter int MAX_BEATS  = 18
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_SRC-1:0]      tlp_tx_en,
   input  logic [5:0]              tx_buf_av,
   input  logic [NUM_SRC*64-1:0]   src_data,
   input  logic [NUM_SRC*8-1:0]    src_keep,
   input  logic [NUM_SRC-1:0]      src_last,
   input  logic [NUM_SRC-1:0]      src_valid,
   output logic [NUM_SRC-1:0]      src_ready,
   output logic [63:0]             tx_data,
   output logic [7:0]              tx_keep,
   output logic                    tx_last,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [NUM_SRC-1:0]      grant,
   output logic                    err_overlen
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CW = $clog2(MAX_BEATS + 2);

   typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [PW-1:0]        gidx_q, gidx_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
   logic                 err_q, err_d;

   logic [NUM_SRC-1:0]   req;
   logic                 sel_found;
   logic [PW-1:0]        sel_idx;
   logic                 xfer;

   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
      int t;
      t = int'(base) + k;
      if (t >= NUM_SRC) t = t - NUM_SRC;
      return PW'(t);
   endfunction

   // first eligible source scanning upward from rr_ptr, wrapping modulo NUM_SRC
   always_comb begin
      req       = src_valid & tlp_tx_en;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!sel_found && req[rr_idx(rr_ptr_q, k)]) begin
            sel_found = 1'b1;
            sel_idx   = rr_idx(rr_ptr_q, k);
         end
      end
   end

   always_comb begin
      tx_data   = '0;
      tx_keep   = '0;
      tx_last   = 1'b0;
      tx_valid  = 1'b0;
      src_ready = '0;
      if (state_q == ST_XFER) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
               tx_data      = src_data[64*i +: 64];
               tx_keep      = src_keep[8*i +: 8];
               tx_last      = src_last[i];
               tx_valid     = src_valid[i];
               src_ready[i] = tx_ready;
            end
         end
      end
      xfer = tx_valid & tx_ready;
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if ((tx_buf_av >= 6'(MIN_BUF_AV)) && sel_found) begin
               state_d    = ST_XFER;
               grant_d    = NUM_SRC'(1) << sel_idx;
               gidx_d     = sel_idx;
               beat_cnt_d = '0;
            end
         end
         ST_XFER: begin
            if (xfer) begin
               if (beat_cnt_q == CW'(MAX_BEATS)) err_d = 1'b1;
               // saturate so an over-long packet cannot wrap back into range
               if (beat_cnt_q != CW'(MAX_BEATS + 1)) beat_cnt_d = beat_cnt_q + 1'b1;
               if (tx_last) begin
                  state_d  = ST_IDLE;
                  grant_d  = '0;
                  rr_ptr_d = rr_idx(gidx_q, 1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   assign grant       = grant_q;
   assign err_overlen = err_q;

endmodule

// File: tb/tb_pcileech_tlps64_tx_arbiter.sv
// Bench for pcileech_tlps64_tx_arbiter: randomized packet sources checked every cycle
// against a packet-level round-robin reference model, plus directed scenarios.
module tb_pcileech_tlps64_tx_arbiter;
   localparam int N    = 4;
   localparam int MAXB = 18;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      tlp_tx_en;
   logic [5:0]        tx_buf_av;
   logic [N*64-1:0]   src_data;
   logic [N*8-1:0]    src_keep;
   logic [N-1:0]      src_last, src_valid, src_ready;
   logic [63:0]       tx_data;
   logic [7:0]        tx_keep;
   logic              tx_last, tx_valid, tx_ready;
   logic [N-1:0]      grant;
   logic              err_overlen;

   always #5 clk = ~clk;

   pcileech_tlps64_tx_arbiter #(.NUM_SRC(N), .MIN_BUF_AV(2), .MAX_BEATS(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .tlp_tx_en(tlp_tx_en), .tx_buf_av(tx_buf_av),
      .src_data(src_data), .src_keep(src_keep), .src_last(src_last),
      .src_valid(src_valid), .src_ready(src_ready), .tx_data(tx_data),
      .tx_keep(tx_keep), .tx_last(tx_last), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .grant(grant), .err_overlen(err_overlen)
   );

   int vectors = 0, miscompares = 0;

   // reference model: current owner (-1 idle), next round-robin start, beats sent, sticky error
   int m_owner, m_rr, m_cnt;
   bit m_err;

   // per-source packet generators
   int g_len[N], g_bi[N], g_seq[N], fix_len[N];
   int p_valid = 100, p_ready = 100;
   bit rp_mode = 0, rand_cfg = 0;
   int rp_idx = 0;
   logic [N-1:0] en_cfg = '1;
   logic [5:0]   buf_cfg = 6'd8;
   int dut_xfers = 0;
   bit dut_last_xfer = 0;

   function automatic logic [63:0] beat_data(int i, int seq, int bi);
      return (64'(i) << 56) | (64'(seq) << 24) | 64'(bi);
   endfunction

   function automatic logic [7:0] beat_keep(int i, int bi);
      return 8'((bi * 37 + i * 11 + 1) % 256);
   endfunction

   function automatic int new_len(int i);
      if (fix_len[i] > 0) return fix_len[i];
      return int'($urandom_range(20, 1));
   endfunction

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_cnt = 0; m_err = 0;
      for (int i = 0; i < N; i++) begin
         g_bi[i] = 0; g_seq[i]++; g_len[i] = new_len(i);
      end
   endtask

   task automatic drive();
      if (rand_cfg) begin
         tlp_tx_en = N'($urandom);
         tx_buf_av = 6'($urandom_range(4, 0));
      end else begin
         tlp_tx_en = en_cfg;
         tx_buf_av = buf_cfg;
      end
      for (int i = 0; i < N; i++) begin
         src_data[64*i +: 64] = beat_data(i, g_seq[i], g_bi[i]);
         src_keep[8*i +: 8]   = beat_keep(i, g_bi[i]);
         src_last[i]          = (g_bi[i] == g_len[i] - 1);
         src_valid[i]         = (int'($urandom_range(99, 0)) < p_valid);
      end
      if (rp_mode) tx_ready = (rp_idx % 4 == 0) || (rp_idx % 4 == 3);
      else         tx_ready = (int'($urandom_range(99, 0)) < p_ready);
   endtask

   // one clock: drive, check at negedge against the model, advance the model, return at posedge+1
   task automatic step(input string tag);
      logic [N-1:0] eg, er;
      logic ev, el;
      logic [63:0] ed;
      logic [7:0] ek;
      bit bad, found;
      int g;
      drive();
      @(negedge clk);
      eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0; ek = '0;
      if (rst_n && m_owner >= 0) begin
         g = m_owner;
         eg[g] = 1'b1; ev = src_valid[g]; el = src_last[g];
         ed = src_data[64*g +: 64]; ek = src_keep[8*g +: 8]; er[g] = tx_ready;
      end
      bad = (grant !== eg) || (tx_valid !== ev) || (src_ready !== er) || (err_overlen !== m_err);
      if (!rst_n || m_owner >= 0) bad = bad || (tx_data !== ed) || (tx_keep !== ek) || (tx_last !== el);
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL %s t=%0t: grant=%b exp %b valid=%b exp %b ready=%b exp %b last=%b exp %b data=%h exp %h keep=%h exp %h err=%b exp %b",
                  tag, $time, grant, eg, tx_valid, ev, src_ready, er, tx_last, el, tx_data, ed, tx_keep, ek, err_overlen, m_err);
      end
      if (tx_valid === 1'b1 && tx_ready) begin
         dut_xfers++;
         dut_last_xfer = (tx_last === 1'b1);
      end else begin
         dut_last_xfer = 0;
      end
      if (!rst_n) begin
         model_reset();
      end else if (m_owner < 0) begin
         if (tx_buf_av >= 6'd2 && |(src_valid & tlp_tx_en)) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               if (!found && src_valid[(m_rr + k) % N] && tlp_tx_en[(m_rr + k) % N]) begin
                  found = 1; m_owner = (m_rr + k) % N; m_cnt = 0;
               end
            end
         end
      end else if (src_valid[m_owner] && tx_ready) begin
         g = m_owner;
         if (m_cnt == MAXB) m_err = 1;
         if (m_cnt < MAXB + 1) m_cnt++;
         if (src_last[g]) begin
            m_owner = -1; m_rr = (g + 1) % N;
            g_bi[g] = 0; g_seq[g]++; g_len[g] = new_len(g);
         end else begin
            g_bi[g]++;
         end
      end
      rp_idx++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      step("reset");
      step("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; p_valid = 100; p_ready = 100; en_cfg = '1; buf_cfg = 6'd8;
      for (int i = 0; i < N; i++) fix_len[i] = 3;
      model_reset();
      step("reset_hold");
      step("reset_hold");
      vectors++;
      if (tx_valid !== 1'b0 || src_ready !== '0 || grant !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b ready=%b grant=%b, need 0/0/0", tx_valid, src_ready, grant);
      end
      rst_n = 1'b1;
      step("reset_release");
      vectors++;
      if (grant !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_first_grant: grant=%b, need 0001", grant);
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] glog[$];
      logic [N-1:0] prev;
      logic [N-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < N; i++) fix_len[i] = 3;
      en_cfg = '1; p_valid = 100; p_ready = 100;
      do_reset();
      prev = '0;
      for (int c = 0; c < 24; c++) begin
         step("fairness");
         if (grant != '0 && prev == '0) glog.push_back(grant);
         prev = grant;
      end
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (k >= glog.size()) begin
            miscompares++;
            $display("FAIL fairness_seq[%0d]: no grant seen, need %b", k, exp_seq[k]);
         end else if (glog[k] !== exp_seq[k]) begin
            miscompares++;
            $display("FAIL fairness_seq[%0d]: grant=%b, need %b", k, glog[k], exp_seq[k]);
         end
      end
   endtask

   task automatic test_mask();
      bit seen2 = 0;
      for (int i = 0; i < N; i++) fix_len[i] = 2;
      en_cfg = 4'b0100;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         step("mask");
         vectors++;
         if ((grant & 4'b1011) != '0) begin
            miscompares++;
            $display("FAIL mask_only_src2: grant=%b, need 0100 or 0000", grant);
         end
         if (grant[2]) seen2 = 1;
      end
      vectors++;
      if (!seen2) begin
         miscompares++;
         $display("FAIL mask_src2_granted: src2 granted=0, need 1");
      end
      en_cfg = '1;
   endtask

   task automatic test_buf_gating();
      buf_cfg = 6'd1;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         step("buf_low");
         vectors++;
         if (grant !== '0) begin
            miscompares++;
            $display("FAIL buf_low_no_grant: grant=%b, need 0000", grant);
         end
      end
      buf_cfg = 6'd2;
      step("buf_two");
      vectors++;
      if (grant !== 4'b0001) begin
         miscompares++;
         $display("FAIL buf_two_grant: grant=%b, need 0001", grant);
      end
      buf_cfg = 6'd8;
   endtask

   task automatic test_back_pressure();
      bit done = 0;
      fix_len[1] = 18;
      en_cfg = 4'b0010;
      do_reset();
      dut_xfers = 0;
      rp_mode = 1; rp_idx = 0;
      for (int c = 0; c < 120 && !done; c++) begin
         step("back_pressure");
         if (dut_last_xfer) done = 1;
      end
      rp_mode = 0;
      vectors++;
      if (!done || dut_xfers != 18) begin
         miscompares++;
         $display("FAIL bp_beats: done=%0d beats=%0d, need 1 and 18", done, dut_xfers);
      end
      vectors++;
      if (err_overlen !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_no_err: err_overlen=%b, need 0", err_overlen);
      end
      en_cfg = '1;
   endtask

   task automatic test_overlen();
      bit done = 0;
      fix_len[0] = 19;
      en_cfg = 4'b0001;
      do_reset();
      dut_xfers = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         step("overlen");
         if (dut_xfers == 18 && !dut_last_xfer) begin
            vectors++;
            if (err_overlen !== 1'b0) begin
               miscompares++;
               $display("FAIL overlen_beat18: err_overlen=%b, need 0", err_overlen);
            end
         end
         if (dut_xfers == 19) begin
            done = 1;
            vectors++;
            if (err_overlen !== 1'b1) begin
               miscompares++;
               $display("FAIL overlen_beat19: err_overlen=%b, need 1", err_overlen);
            end
         end
      end
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL overlen_timeout: beats=%0d, need 19", dut_xfers);
      end
      fix_len[0] = 4;
      for (int c = 0; c < 20; c++) step("overlen_sticky");
      vectors++;
      if (err_overlen !== 1'b1) begin
         miscompares++;
         $display("FAIL overlen_sticky: err_overlen=%b, need 1", err_overlen);
      end
      do_reset();
      vectors++;
      if (err_overlen !== 1'b0) begin
         miscompares++;
         $display("FAIL overlen_reset_clear: err_overlen=%b, need 0", err_overlen);
      end
      en_cfg = '1;
   endtask

   task automatic test_reset_mid();
      bit hit = 0;
      fix_len[0] = 10;
      en_cfg = 4'b0001;
      do_reset();
      for (int c = 0; c < 40 && !hit; c++) begin
         step("reset_mid_run");
         if (m_owner == 0 && g_bi[0] == 4) hit = 1;
      end
      if (!hit) begin
         vectors++; miscompares++;
         $display("FAIL reset_mid_reach: beat5 reached=0, need 1");
      end
      drive();
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (tx_valid !== 1'b0 || grant !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_immediate: valid=%b grant=%b, need 0/0000", tx_valid, grant);
      end
      model_reset();
      @(posedge clk); #1;
      step("reset_mid_hold");
      rst_n = 1'b1;
      en_cfg = '1;
      step("reset_mid_release");
      vectors++;
      if (grant !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_mid_rr0: grant=%b, need 0001", grant);
      end
      for (int c = 0; c < 20; c++) step("reset_mid_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < N; i++) fix_len[i] = 0;
      p_valid = 70; p_ready = 70; rand_cfg = 1;
      do_reset();
      for (int c = 0; c < 3000; c++) step("random");
      rand_cfg = 0; p_valid = 100; p_ready = 100;
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_fairness();
      test_mask();
      test_buf_gating();
      test_back_pressure();
      test_overlen();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
